// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: opcodes (common with issue), ROB depth and
// reservation-station index constants.
package tomasulo_pkg;

  localparam int ROB_DEPTH = 8;
  localparam int OP_W      = 4;

  // Opcodes, shared with the issue stage
  localparam logic [OP_W-1:0] LOAD  = 4'd0;
  localparam logic [OP_W-1:0] STORE = 4'd1;
  localparam logic [OP_W-1:0] ADD   = 4'd2;
  localparam logic [OP_W-1:0] SUB   = 4'd3;
  localparam logic [OP_W-1:0] MUL   = 4'd4;
  localparam logic [OP_W-1:0] DIV   = 4'd5;

  // Reservation-station indices
  localparam logic [3:0] ADD1    = 4'd7;
  localparam logic [3:0] ADD2    = 4'd8;
  localparam logic [3:0] ADD3    = 4'd9;
  localparam logic [3:0] MUL1    = 4'd10;
  localparam logic [3:0] MUL2    = 4'd11;
  localparam logic [3:0] GARBAGE = 4'd12;

  // A STORE retires to the store path instead of the register file
  function automatic logic op_is_store(input logic [OP_W-1:0] op);
    return op == STORE;
  endfunction

endpackage

// File: rtl/rob_commit_if.sv
// Issue / CDB / commit bus of the reorder buffer.
// Optional operand lookup ports are present when ROB_FWD_EN is defined.
interface rob_commit_if #(
  parameter int ROB_DEPTH = 8,
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int OP_W      = 4
);
  localparam int IDX_W = $clog2(ROB_DEPTH);

  logic                 issue_valid;
  logic [IDX_W-1:0]     issue_idx;
  logic [OP_W-1:0]      issue_op;
  logic [REG_AW-1:0]    issue_dest;
  logic                 issue_err;

  logic                 cdb_valid;
  logic [IDX_W-1:0]     cdb_rob_idx;
  logic [DATA_W-1:0]    cdb_value;

  logic [ROB_DEPTH-1:0] busy_rb;
  logic                 rob_full;

  logic                 commit_valid;
  logic                 commit_ready;
  logic [IDX_W-1:0]     commit_idx;
  logic [REG_AW-1:0]    commit_dest;
  logic [DATA_W-1:0]    commit_value;
  logic                 commit_is_store;

`ifdef ROB_FWD_EN
  logic [IDX_W-1:0]     fwd_idx_a;
  logic [IDX_W-1:0]     fwd_idx_b;
  logic                 fwd_hit_a;
  logic                 fwd_hit_b;
  logic [DATA_W-1:0]    fwd_val_a;
  logic [DATA_W-1:0]    fwd_val_b;

  modport master (
    output issue_valid, issue_idx, issue_op, issue_dest,
    output cdb_valid, cdb_rob_idx, cdb_value,
    output commit_ready,
    output fwd_idx_a, fwd_idx_b,
    input  issue_err, busy_rb, rob_full,
    input  commit_valid, commit_idx, commit_dest, commit_value, commit_is_store,
    input  fwd_hit_a, fwd_hit_b, fwd_val_a, fwd_val_b
  );

  modport slave (
    input  issue_valid, issue_idx, issue_op, issue_dest,
    input  cdb_valid, cdb_rob_idx, cdb_value,
    input  commit_ready,
    input  fwd_idx_a, fwd_idx_b,
    output issue_err, busy_rb, rob_full,
    output commit_valid, commit_idx, commit_dest, commit_value, commit_is_store,
    output fwd_hit_a, fwd_hit_b, fwd_val_a, fwd_val_b
  );
`else
  modport master (
    output issue_valid, issue_idx, issue_op, issue_dest,
    output cdb_valid, cdb_rob_idx, cdb_value,
    output commit_ready,
    input  issue_err, busy_rb, rob_full,
    input  commit_valid, commit_idx, commit_dest, commit_value, commit_is_store
  );

  modport slave (
    input  issue_valid, issue_idx, issue_op, issue_dest,
    input  cdb_valid, cdb_rob_idx, cdb_value,
    input  commit_ready,
    output issue_err, busy_rb, rob_full,
    output commit_valid, commit_idx, commit_dest, commit_value, commit_is_store
  );
`endif

endinterface

// File: rtl/rob_ptr_ctr.sv
// Wrapping ROB pointer with increment enable (used for head and tail).
module rob_ptr_ctr #(
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [IDX_W-1:0] ptr
);

  // Advance by one on enable; natural binary wrap since depth is a power of 2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + IDX_W'(1);
    end
  end

endmodule

// File: rtl/rob_commit.sv
// rob_commit: 8-entry reorder buffer. Accepts in-order allocations from issue,
// captures CDB results, retires in program order through a valid/ready commit
// port, and exports the registered per-entry busy flags.
// Optional feature macro: ROB_FWD_EN (adds two operand lookup ports).
module rob_commit #(
  parameter int ROB_DEPTH = 8,
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int OP_W      = 4
) (
  input  logic          clk,
  input  logic          rst,
  rob_commit_if.slave   bus
);
  import tomasulo_pkg::*;

  localparam int IDX_W = $clog2(ROB_DEPTH);
  localparam int CNT_W = $clog2(ROB_DEPTH + 1);

  // Control state (reset)
  logic [ROB_DEPTH-1:0] busy_q;
  logic [ROB_DEPTH-1:0] ready_q;
  logic [CNT_W-1:0]     count_q;
  logic                 issue_err_q;
  logic [IDX_W-1:0]     head;
  logic [IDX_W-1:0]     tail;

  // Entry payload (not reset; qualified by busy/ready)
  logic [OP_W-1:0]      op_q    [ROB_DEPTH];
  logic [REG_AW-1:0]    dest_q  [ROB_DEPTH];
  logic [DATA_W-1:0]    value_q [ROB_DEPTH];

  logic issue_ok;
  logic cdb_hit;
  logic retire;
  logic head_valid;

  // Handshake decode. A full ROB has busy[tail] set, so an issue racing the
  // head retire is rejected: the freed slot is only visible next cycle.
  always_comb begin
    issue_ok   = bus.issue_valid && (bus.issue_idx == tail) && !busy_q[tail];
    cdb_hit    = bus.cdb_valid && busy_q[bus.cdb_rob_idx] &&
                 !(issue_ok && (bus.issue_idx == bus.cdb_rob_idx));
    head_valid = busy_q[head] && ready_q[head];
    retire     = head_valid && bus.commit_ready;
  end

  rob_ptr_ctr #(.IDX_W(IDX_W)) u_tail (
    .clk (clk),
    .rst (rst),
    .inc (issue_ok),
    .ptr (tail)
  );

  rob_ptr_ctr #(.IDX_W(IDX_W)) u_head (
    .clk (clk),
    .rst (rst),
    .inc (retire),
    .ptr (head)
  );

  // Per-entry busy/ready flags: allocate, complete, retire
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= '0;
      ready_q <= '0;
    end else begin
      if (issue_ok) begin
        busy_q[tail]  <= 1'b1;
        ready_q[tail] <= 1'b0;
      end
      if (cdb_hit) begin
        ready_q[bus.cdb_rob_idx] <= 1'b1;
      end
      if (retire) begin
        busy_q[head]  <= 1'b0;
        ready_q[head] <= 1'b0;
      end
    end
  end

  // Occupancy count; full/empty never inferred from pointer equality
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      unique case ({issue_ok, retire})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Registered one-cycle reject pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_err_q <= 1'b0;
    end else begin
      issue_err_q <= bus.issue_valid && !issue_ok;
    end
  end

  // Entry payload capture: op/dest at allocation, value from the CDB
  always_ff @(posedge clk) begin
    if (issue_ok) begin
      op_q[tail]   <= bus.issue_op;
      dest_q[tail] <= bus.issue_dest;
    end
    if (cdb_hit) begin
      value_q[bus.cdb_rob_idx] <= bus.cdb_value;
    end
  end

  // Outputs: commit fields come straight from registered head state
  always_comb begin
    bus.issue_err       = issue_err_q;
    bus.busy_rb         = busy_q;
    bus.rob_full        = (count_q == CNT_W'(ROB_DEPTH));
    bus.commit_valid    = head_valid;
    bus.commit_idx      = head;
    bus.commit_dest     = dest_q[head];
    bus.commit_value    = value_q[head];
    bus.commit_is_store = op_is_store(op_q[head]);
  end

`ifdef ROB_FWD_EN
  // Operand lookup of completed but uncommitted results
  always_comb begin
    bus.fwd_hit_a = busy_q[bus.fwd_idx_a] && ready_q[bus.fwd_idx_a];
    bus.fwd_val_a = value_q[bus.fwd_idx_a];
    bus.fwd_hit_b = busy_q[bus.fwd_idx_b] && ready_q[bus.fwd_idx_b];
    bus.fwd_val_b = value_q[bus.fwd_idx_b];
  end
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit with a commit scoreboard.
module tb_rob_commit;
  import tomasulo_pkg::*;

  localparam int DEPTH = 8;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int OW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  rob_commit_if #(.ROB_DEPTH(DEPTH), .DATA_W(DW), .REG_AW(AW), .OP_W(OW)) bus ();

  rob_commit #(.ROB_DEPTH(DEPTH), .DATA_W(DW), .REG_AW(AW), .OP_W(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [2:0]    idx;
    logic [AW-1:0] dest;
    logic          st;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] m_val   [DEPTH];
  logic [7:0]    m_busy;
  logic [7:0]    m_ready;
  logic [2:0]    m_tail;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.issue_valid  = 1'b0;
    bus.issue_idx    = '0;
    bus.issue_op     = '0;
    bus.issue_dest   = '0;
    bus.cdb_valid    = 1'b0;
    bus.cdb_rob_idx  = '0;
    bus.cdb_value    = '0;
    bus.commit_ready = 1'b0;
`ifdef ROB_FWD_EN
    bus.fwd_idx_a    = '0;
    bus.fwd_idx_b    = '0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    m_busy  = '0;
    m_ready = '0;
    m_tail  = '0;
    tick();
  endtask

  task automatic do_issue(input logic [2:0] idx, input logic [OW-1:0] op,
                          input logic [AW-1:0] dest, input logic ok);
    exp_t e;
    bus.issue_valid = 1'b1;
    bus.issue_idx   = idx;
    bus.issue_op    = op;
    bus.issue_dest  = dest;
    tick();
    bus.issue_valid = 1'b0;
    if (ok) begin
      e.idx = idx; e.dest = dest; e.st = (op == STORE);
      exp_q.push_back(e);
      m_busy[idx]  = 1'b1;
      m_ready[idx] = 1'b0;
      m_tail       = m_tail + 3'd1;
    end
    chk("issue_err", {63'd0, bus.issue_err}, {63'd0, !ok});
    chk("busy_after_issue", {56'd0, bus.busy_rb}, {56'd0, m_busy});
  endtask

  task automatic do_cdb(input logic [2:0] idx, input logic [DW-1:0] val);
    bus.cdb_valid   = 1'b1;
    bus.cdb_rob_idx = idx;
    bus.cdb_value   = val;
    tick();
    bus.cdb_valid   = 1'b0;
    if (m_busy[idx]) begin
      m_val[idx]   = val;
      m_ready[idx] = 1'b1;
    end
  endtask

  task automatic check_front(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = exp_q[0];
    chk({tag, "_valid"}, {63'd0, bus.commit_valid}, 64'd1);
    chk({tag, "_idx"},   {61'd0, bus.commit_idx}, {61'd0, e.idx});
    chk({tag, "_dest"},  {59'd0, bus.commit_dest}, {59'd0, e.dest});
    chk({tag, "_value"}, {32'd0, bus.commit_value}, {32'd0, m_val[e.idx]});
    chk({tag, "_store"}, {63'd0, bus.commit_is_store}, {63'd0, e.st});
  endtask

  task automatic do_commit(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (!bus.commit_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_wait"}, {63'd0, bus.commit_valid}, 64'd1);
    check_front(tag);
    bus.commit_ready = 1'b1;
    tick();
    bus.commit_ready = 1'b0;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      m_busy[e.idx]  = 1'b0;
      m_ready[e.idx] = 1'b0;
    end
    chk({tag, "_busy"}, {56'd0, bus.busy_rb}, {56'd0, m_busy});
  endtask

  initial begin
    logic [DW-1:0] v;
    logic [AW-1:0] d;
    logic [OW-1:0] op;
    exp_t          e;

    // ---- reset state
    do_reset();
    chk("rst_busy",   {56'd0, bus.busy_rb}, 64'd0);
    chk("rst_full",   {63'd0, bus.rob_full}, 64'd0);
    chk("rst_cvalid", {63'd0, bus.commit_valid}, 64'd0);
    chk("rst_err",    {63'd0, bus.issue_err}, 64'd0);

    // ---- 1: single ADD round trip
    do_issue(3'd0, ADD, 5'd3, 1'b1);
    chk("t1_not_ready", {63'd0, bus.commit_valid}, 64'd0);
    do_cdb(3'd0, 32'h55);
    chk("t1_valid_next", {63'd0, bus.commit_valid}, 64'd1);
    do_commit("t1");
    chk("t1_busy_zero", {56'd0, bus.busy_rb}, 64'd0);

    // ---- 2: fill, then reject
    do_reset();
    for (int i = 0; i < 8; i++) do_issue(3'(i), LOAD, 5'(i + 10), 1'b1);
    chk("t2_busy_ff", {56'd0, bus.busy_rb}, 64'hFF);
    chk("t2_full", {63'd0, bus.rob_full}, 64'd1);
    do_issue(3'd0, ADD, 5'd1, 1'b0);
    chk("t2_full_kept", {63'd0, bus.rob_full}, 64'd1);
    tick();
    chk("t2_err_pulse", {63'd0, bus.issue_err}, 64'd0);

    // ---- 4: full, head ready, issue races the retire
    do_cdb(3'd0, 32'hCAFE_0000);
    check_front("t4_pre");
    bus.issue_valid  = 1'b1;
    bus.issue_idx    = 3'd0;
    bus.issue_op     = SUB;
    bus.issue_dest   = 5'd7;
    bus.commit_ready = 1'b1;
    tick();
    bus.issue_valid  = 1'b0;
    bus.commit_ready = 1'b0;
    e = exp_q.pop_front();
    m_busy[e.idx]  = 1'b0;
    m_ready[e.idx] = 1'b0;
    chk("t4_err", {63'd0, bus.issue_err}, 64'd1);
    chk("t4_busy", {56'd0, bus.busy_rb}, 64'hFE);
    chk("t4_not_full", {63'd0, bus.rob_full}, 64'd0);
    do_issue(3'd0, SUB, 5'd7, 1'b1);
    chk("t4_full_again", {63'd0, bus.rob_full}, 64'd1);

    // ---- 3: out-of-order completion, in-order retire; dropped CDB; issue beats CDB
    do_reset();
    do_cdb(3'd5, 32'hDEAD);
    chk("t3_drop_busy", {56'd0, bus.busy_rb}, 64'd0);
    do_issue(3'd0, ADD, 5'd1, 1'b1);
    do_issue(3'd1, MUL, 5'd2, 1'b1);
    do_issue(3'd2, STORE, 5'd3, 1'b1);
    do_cdb(3'd2, 32'h2222);
    chk("t3_wait2", {63'd0, bus.commit_valid}, 64'd0);
    do_cdb(3'd1, 32'h1111);
    chk("t3_wait1", {63'd0, bus.commit_valid}, 64'd0);
    do_cdb(3'd0, 32'h0000_1000);
    do_commit("t3_c0");
    do_commit("t3_c1");
    do_commit("t3_c2");
    // same-cycle issue and CDB on idx3: entry must start not ready
    bus.issue_valid = 1'b1; bus.issue_idx = 3'd3; bus.issue_op = DIV; bus.issue_dest = 5'd9;
    bus.cdb_valid   = 1'b1; bus.cdb_rob_idx = 3'd3; bus.cdb_value = 32'hBAD;
    tick();
    bus.issue_valid = 1'b0; bus.cdb_valid = 1'b0;
    e.idx = 3'd3; e.dest = 5'd9; e.st = 1'b0;
    exp_q.push_back(e);
    m_busy[3] = 1'b1; m_ready[3] = 1'b0; m_tail = 3'd4;
    chk("t3_race_busy", {56'd0, bus.busy_rb}, 64'h08);
    chk("t3_race_notready", {63'd0, bus.commit_valid}, 64'd0);
    do_cdb(3'd3, 32'h3333);
    do_commit("t3_c3");

    // ---- 5: stall with stable fields, then many wraps
    do_reset();
    do_issue(3'd0, STORE, 5'd21, 1'b1);
    do_cdb(3'd0, 32'h5A5A_A5A5);
    for (int c = 0; c < 5; c++) begin
      check_front("t5_stall");
      tick();
    end
    do_commit("t5_release");
    for (int k = 0; k < 24; k++) begin
      op = (k % 3 == 0) ? STORE : ADD;
      d  = 5'($urandom_range(0, 31));
      v  = $urandom;
      do_issue(m_tail, op, d, 1'b1);
      if (k % 2 == 0) do_issue(m_tail, MUL, 5'd30, 1'b1);
      do_cdb(exp_q[0].idx, v);
      if (exp_q.size() > 1) do_cdb(exp_q[1].idx, v ^ 32'hFFFF);
      while (exp_q.size() != 0 && m_ready[exp_q[0].idx]) do_commit("t5_wrap");
    end
    chk("t5_final_busy", {56'd0, bus.busy_rb}, {56'd0, m_busy});

`ifdef ROB_FWD_EN
    // ---- 6: operand lookup
    do_reset();
    for (int i = 0; i < 6; i++) do_issue(3'(i), ADD, 5'(i), 1'b1);
    do_cdb(3'd4, 32'hAB);
    bus.fwd_idx_a = 3'd4;
    bus.fwd_idx_b = 3'd2;
    #1;
    chk("t6_hit_a", {63'd0, bus.fwd_hit_a}, 64'd1);
    chk("t6_val_a", {32'd0, bus.fwd_val_a}, 64'hAB);
    chk("t6_hit_b", {63'd0, bus.fwd_hit_b}, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
